kf8255_bus_sequencer: RTL and testbench

- Two-requester arbiter and bus-cycle sequencer in front of one KF8255 PPI instance.
- Converts simple request/done transactions into properly timed chip_select_n / read_enable_n / write_enable_n cycles with stable address and data.
- Keeps address and data stable across the whole strobe and holds chip select after write strobe release, so the PPI's write-edge detector fires.
- Sits between on-chip masters (e.g. keyboard scan engine, config engine) and the PPI bus pins.

---
 rtl/kf8255_bus_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_kf8255_bus_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kf8255_bus_sequencer.sv
// Two-requester round-robin arbiter and timed bus-cycle sequencer for a KF8255 PPI.
// Define KF8255_SEQ_INIT_EN to write INIT_CONTROL_WORD to address 3 after reset.
module kf8255_bus_sequencer #(
    parameter int unsigned SETUP_CYCLES      = 1,
    parameter int unsigned STROBE_CYCLES     = 2,
    parameter int unsigned HOLD_CYCLES       = 1,
    parameter logic [7:0]  INIT_CONTROL_WORD = 8'h9B
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic [1:0] req0_address,
    input  logic [7:0] req0_wdata,
    output logic       req0_done,
    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic [1:0] req1_address,
    input  logic [7:0] req1_wdata,
    output logic       req1_done,
    output logic [7:0] rdata,
    output logic       ppi_chip_select_n,
    output logic       ppi_read_enable_n,
    output logic       ppi_write_enable_n,
    output logic [1:0] ppi_address,
    output logic [7:0] ppi_data_out,
    input  logic [7:0] ppi_data_in,
    output logic       busy
);

    localparam logic [3:0] SETUP_N  = (SETUP_CYCLES  == 0) ? 4'd1 : SETUP_CYCLES[3:0];
    localparam logic [3:0] STROBE_N = (STROBE_CYCLES == 0) ? 4'd1 : STROBE_CYCLES[3:0];
    localparam logic [3:0] HOLD_N   = (HOLD_CYCLES   == 0) ? 4'd1 : HOLD_CYCLES[3:0];

`ifdef KF8255_SEQ_INIT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE, S_INIT
    } state_t;
    localparam state_t RESET_STATE = S_INIT;
    localparam logic   RESET_BUSY  = 1'b1;
    logic init_q, init_d;
    logic in_init;
    assign in_init = init_q;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE
    } state_t;
    localparam state_t RESET_STATE = S_IDLE;
    localparam logic   RESET_BUSY  = 1'b0;
    logic in_init;
    assign in_init = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic       cmd_write_q, cmd_write_d;
    logic [1:0] cmd_address_q, cmd_address_d;
    logic [7:0] cmd_wdata_q, cmd_wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cmd_write_d   = cmd_write_q;
        cmd_address_d = cmd_address_q;
        cmd_wdata_d   = cmd_wdata_q;
        rdata_d       = rdata_q;
`ifdef KF8255_SEQ_INIT_EN
        init_d        = init_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    // Both pending: the requester not served last wins.
                    grant_d       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    cmd_write_d   = grant_d ? req1_write   : req0_write;
                    cmd_address_d = grant_d ? req1_address : req0_address;
                    cmd_wdata_d   = grant_d ? req1_wdata   : req0_wdata;
                    state_d       = S_SETUP;
                    cnt_d         = SETUP_N;
                end
            end
            S_SETUP: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_STROBE;
                    cnt_d   = STROBE_N;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_N;
                    if (!cmd_write_q) rdata_d = ppi_data_in;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 4'd1) state_d = S_DONE;
                else cnt_d = cnt_q - 4'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!in_init) last_grant_d = grant_q;
`ifdef KF8255_SEQ_INIT_EN
                init_d = 1'b0;
`endif
            end
`ifdef KF8255_SEQ_INIT_EN
            S_INIT: begin
                cmd_write_d   = 1'b1;
                cmd_address_d = 2'b11;
                cmd_wdata_d   = INIT_CONTROL_WORD;
                init_d        = 1'b1;
                state_d       = S_SETUP;
                cnt_d         = SETUP_N;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Bus pins are registered from the next state so they change on clock edges only.
        cs_n_d  = !(state_d == S_SETUP || state_d == S_STROBE || state_d == S_HOLD);
        rd_n_d  = !(state_d == S_STROBE && !cmd_write_d);
        wr_n_d  = !(state_d == S_STROBE && cmd_write_d);
        done0_d = (state_d == S_DONE) && !grant_d && !in_init;
        done1_d = (state_d == S_DONE) && grant_d && !in_init;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RESET_STATE;
            cnt_q         <= 4'd0;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            cmd_write_q   <= 1'b0;
            cmd_address_q <= 2'd0;
            cmd_wdata_q   <= 8'd0;
            rdata_q       <= 8'd0;
            cs_n_q        <= 1'b1;
            rd_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            busy_q        <= RESET_BUSY;
`ifdef KF8255_SEQ_INIT_EN
            init_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cmd_write_q   <= cmd_write_d;
            cmd_address_q <= cmd_address_d;
            cmd_wdata_q   <= cmd_wdata_d;
            rdata_q       <= rdata_d;
            cs_n_q        <= cs_n_d;
            rd_n_q        <= rd_n_d;
            wr_n_q        <= wr_n_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            busy_q        <= busy_d;
`ifdef KF8255_SEQ_INIT_EN
            init_q        <= init_d;
`endif
        end
    end

    assign req0_done          = done0_q;
    assign req1_done          = done1_q;
    assign rdata              = rdata_q;
    assign ppi_chip_select_n  = cs_n_q;
    assign ppi_read_enable_n  = rd_n_q;
    assign ppi_write_enable_n = wr_n_q;
    assign ppi_address        = cmd_address_q;
    assign ppi_data_out       = cmd_wdata_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_kf8255_bus_sequencer.sv
// Directed bench: default timing, 3/4/2 timing and 0/0/0 timing instances.
module tb_kf8255_bus_sequencer;

    typedef struct {
        bit         sel;
        bit         wr;
        logic [1:0] addr;
        logic [7:0] wd;
        logic [7:0] din;
        logic [7:0] exp_rd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] v0 = 3'b000;
    logic       v1 = 1'b0;
    logic       t_write = 1'b0;
    logic [1:0] t_addr = 2'd0;
    logic [7:0] t_wdata = 8'd0;
    logic [7:0] din = 8'd0;

    logic [2:0] cs_n, rd_n, wr_n, done0, done1, busy;
    logic [1:0] pa [3];
    logic [7:0] dout [3];
    logic [7:0] rdat [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    kf8255_bus_sequencer u_d (
        .clock(clk), .reset_n(rst_n),
        .req0_valid(v0[0]), .req0_write(t_write), .req0_address(t_addr),
        .req0_wdata(t_wdata), .req0_done(done0[0]),
        .req1_valid(v1), .req1_write(t_write), .req1_address(t_addr),
        .req1_wdata(t_wdata), .req1_done(done1[0]),
        .rdata(rdat[0]), .ppi_chip_select_n(cs_n[0]),
        .ppi_read_enable_n(rd_n[0]), .ppi_write_enable_n(wr_n[0]),
        .ppi_address(pa[0]), .ppi_data_out(dout[0]),
        .ppi_data_in(din), .busy(busy[0])
    );

    kf8255_bus_sequencer #(.SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2)) u_p (
        .clock(clk), .reset_n(rst_n),
        .req0_valid(v0[1]), .req0_write(t_write), .req0_address(t_addr),
        .req0_wdata(t_wdata), .req0_done(done0[1]),
        .req1_valid(1'b0), .req1_write(1'b0), .req1_address(2'd0),
        .req1_wdata(8'd0), .req1_done(done1[1]),
        .rdata(rdat[1]), .ppi_chip_select_n(cs_n[1]),
        .ppi_read_enable_n(rd_n[1]), .ppi_write_enable_n(wr_n[1]),
        .ppi_address(pa[1]), .ppi_data_out(dout[1]),
        .ppi_data_in(din), .busy(busy[1])
    );

    kf8255_bus_sequencer #(.SETUP_CYCLES(0), .STROBE_CYCLES(0), .HOLD_CYCLES(0)) u_z (
        .clock(clk), .reset_n(rst_n),
        .req0_valid(v0[2]), .req0_write(t_write), .req0_address(t_addr),
        .req0_wdata(t_wdata), .req0_done(done0[2]),
        .req1_valid(1'b0), .req1_write(1'b0), .req1_address(2'd0),
        .req1_wdata(8'd0), .req1_done(done1[2]),
        .rdata(rdat[2]), .ppi_chip_select_n(cs_n[2]),
        .ppi_read_enable_n(rd_n[2]), .ppi_write_enable_n(wr_n[2]),
        .ppi_address(pa[2]), .ppi_data_out(dout[2]),
        .ppi_data_in(din), .busy(busy[2])
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 3'b000;
        v1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`ifdef KF8255_SEQ_INIT_EN
        for (int i = 0; i < 100 && busy != 3'b000; i++) @(negedge clk);
        check("init_settle", int'(busy), 0);
`endif
    endtask

    // s/t/h are the effective setup/strobe/hold lengths of the instance.
    task automatic run_txn(input int inst, input vec_t v, input int s,
                           input int t, input int h, input string nm);
        int cs_cnt, stb_cnt, stb_start, bad, other, lat;
        cs_cnt = 0; stb_cnt = 0; stb_start = 0; bad = 0; other = 0; lat = 0;
        @(negedge clk);
        t_write = v.wr; t_addr = v.addr; t_wdata = v.wd; din = ~v.din;
        if (v.sel) v1 = 1'b1;
        else v0[inst] = 1'b1;
        for (int e = 1; e <= 60 && lat == 0; e++) begin
            @(negedge clk);
            if (!cs_n[inst]) begin
                cs_cnt++;
                if (pa[inst] !== v.addr || (v.wr && dout[inst] !== v.wd)) bad++;
            end
            if (!(v.wr ? wr_n[inst] : rd_n[inst])) begin
                if (stb_cnt == 0) stb_start = e;
                stb_cnt++;
            end
            if (!(v.wr ? rd_n[inst] : wr_n[inst])) bad++;
            din = (!rd_n[inst]) ? v.din : ~v.din;
            if (v.sel ? done0[inst] : done1[inst]) other++;
            if (v.sel ? done1[inst] : done0[inst]) begin
                lat = e;
                v0[inst] = 1'b0;
                v1 = 1'b0;
            end
        end
        check({nm, "_latency"}, lat, 1 + s + t + h);
        check({nm, "_cs_cycles"}, cs_cnt, s + t + h);
        check({nm, "_strobe_cycles"}, stb_cnt, t);
        check({nm, "_strobe_start"}, stb_start, 1 + s);
        check({nm, "_bus_stable"}, bad, 0);
        check({nm, "_other_done"}, other, 0);
        @(negedge clk);
        check({nm, "_done_width"}, int'(v.sel ? done1[inst] : done0[inst]), 0);
        check({nm, "_rdata"}, int'(rdat[inst]), int'(v.exp_rd));
        check({nm, "_busy_idle"}, int'(busy[inst]), 0);
    endtask

    task automatic arb_round(input string nm);
        int t0, t1, g2;
        t0 = 0; t1 = 0; g2 = 0;
        @(negedge clk);
        t_write = 1'b1; t_addr = 2'd1; t_wdata = 8'h66;
        v0[0] = 1'b1;
        v1 = 1'b1;
        for (int e = 1; e <= 40 && (t0 == 0 || t1 == 0); e++) begin
            @(negedge clk);
            if (t0 != 0 && g2 == 0 && !cs_n[0]) g2 = e;
            if (done0[0] && t0 == 0) begin
                t0 = e;
                v0[0] = 1'b0;
            end
            if (done1[0] && t1 == 0) begin
                t1 = e;
                v1 = 1'b0;
            end
        end
        check({nm, "_req0_done"}, t0, 5);
        check({nm, "_req1_done"}, t1, 11);
        check({nm, "_second_grant"}, g2, 7);
    endtask

    vec_t vt [5];
    vec_t pv;

    initial begin
        vt[0] = '{1'b0, 1'b1, 2'd0, 8'hA5, 8'h00, 8'h00};
        vt[1] = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h3C, 8'h3C};
        vt[2] = '{1'b0, 1'b1, 2'd1, 8'h5A, 8'hFF, 8'h3C};
        vt[3] = '{1'b0, 1'b0, 2'd3, 8'h00, 8'hC3, 8'hC3};
        vt[4] = '{1'b1, 1'b1, 2'd3, 8'h80, 8'h11, 8'hC3};

        @(negedge clk);
        #1;
        check("rst_strobes", int'({cs_n[0], rd_n[0], wr_n[0]}), 7);
        check("rst_addr_data", int'({pa[0], dout[0]}), 0);
        check("rst_rdata_done", int'({rdat[0], done0[0], done1[0]}), 0);
`ifdef KF8255_SEQ_INIT_EN
        check("rst_busy", int'(busy[0]), 1);
        begin
            int initw, td;
            initw = 0; td = 0;
            @(negedge clk);
            rst_n = 1'b1;
            t_write = 1'b1; t_addr = 2'd0; t_wdata = 8'h11;
            v0[0] = 1'b1;
            for (int e = 1; e <= 40 && td == 0; e++) begin
                @(negedge clk);
                if (!wr_n[0] && !cs_n[0] && pa[0] == 2'd3 && dout[0] == 8'h9B) initw++;
                if (done0[0]) begin
                    td = e;
                    v0[0] = 1'b0;
                end
            end
            check("init_write_cycles", initw, 2);
            check("init_req_done", td, 11);
        end
        do_reset();
`else
        check("rst_busy", int'(busy[0]), 0);
        do_reset();
        begin
            int act;
            act = 0;
            repeat (4) begin
                @(negedge clk);
                if (!cs_n[0] || busy[0]) act++;
            end
            check("idle_after_reset", act, 0);
        end
`endif

        for (int i = 0; i < 5; i++)
            run_txn(0, vt[i], 1, 2, 1, $sformatf("vec%0d", i));

        do_reset();
        arb_round("arb1");
        arb_round("arb2");

        pv = '{1'b0, 1'b1, 2'd2, 8'h4D, 8'h00, 8'h00};
        run_txn(1, pv, 3, 4, 2, "p342_wr");
        pv = '{1'b0, 1'b0, 2'd1, 8'h00, 8'hE7, 8'hE7};
        run_txn(1, pv, 3, 4, 2, "p342_rd");
        pv = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h96, 8'h96};
        run_txn(2, pv, 1, 1, 1, "p000_rd");

        begin
            int seen, dn;
            seen = 0; dn = 0;
            @(negedge clk);
            t_write = 1'b1; t_addr = 2'd1; t_wdata = 8'h77;
            v0[0] = 1'b1;
            for (int e = 1; e <= 20 && seen == 0; e++) begin
                @(negedge clk);
                if (!wr_n[0]) seen = 1;
            end
            check("midrst_in_strobe", seen, 1);
            #1 rst_n = 1'b0;
            #1;
            check("midrst_strobes", int'({cs_n[0], rd_n[0], wr_n[0]}), 7);
            check("midrst_busy", int'(busy[0]), 0);
            v0[0] = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (done0[0]) dn++;
            end
            check("midrst_no_done", dn, 0);
            rst_n = 1'b1;
`ifdef KF8255_SEQ_INIT_EN
            for (int i = 0; i < 100 && busy != 3'b000; i++) @(negedge clk);
`endif
        end
        pv = '{1'b0, 1'b1, 2'd1, 8'h77, 8'h00, 8'h00};
        run_txn(0, pv, 1, 2, 1, "midrst_retry");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
